mips_muldiv: RTL
================

MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 4..64).
REQ-002 The block SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port clk_enable  input  1  state advances only on edges where high.
REQ-005 The block SHALL have port start  input  1  request a new operation.
REQ-006 The block SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The block SHALL have port op_a  input  WIDTH  multiplicand or dividend.
REQ-008 The block SHALL have port op_b  input  WIDTH  multiplier or divisor.
REQ-009 The block SHALL have ports hi_write and lo_write  input  1 each  MTHI and MTLO strobes.
REQ-010 The block SHALL have port write_data  input  WIDTH  data for MTHI and MTLO.
REQ-011 The block SHALL have port busy  output  1  operation in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port div_by_zero  output  1  pulses with done when a DIV or DIVU has op_b==0.
REQ-014 The block SHALL have ports hi and lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 The block SHALL have FSM states IDLE, RUN and FINISH; when clk_enable is low, all registers SHALL hold.
REQ-016 In IDLE, an enabled edge with start=1 SHALL latch op, operand magnitudes (signed ops) or raw values (unsigned), and result-sign flags; clear a WIDTH-bit iteration counter; enter RUN; and set busy=1.
REQ-017 RUN SHALL perform one iteration per enabled edge: shift-add bit for multiply, restoring subtract-shift bit for divide; after exactly WIDTH iterations the FSM SHALL enter FINISH.
REQ-018 FINISH SHALL apply sign correction, load hi/lo, assert done=1 and busy=0 for that cycle, and then return to IDLE.
REQ-019 Latency: with start accepted at edge N and clk_enable constantly high, hi/lo SHALL be valid and done high after edge N+WIDTH+1.
REQ-020 Multiply: {hi,lo} SHALL equal the 2*WIDTH-bit product, two's complement for MULT.
REQ-021 Divide: lo SHALL be the quotient and hi the remainder; for DIV, the quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-022 DIV with op_a = most negative value and op_b = -1 SHALL give lo = most negative value and hi = 0 (no trap).
REQ-023 DIV or DIVU with op_b==0 SHALL skip RUN and go to FINISH on the next edge, giving hi=op_a, lo=all ones, and div_by_zero=1 with done.
REQ-024 start while busy SHALL be ignored, and operand inputs SHALL not affect an operation in progress.
REQ-025 hi_write and lo_write in IDLE SHALL load write_data into hi and lo respectively on the enabled edge; in RUN or FINISH they SHALL be ignored.
REQ-026 start together with hi_write or lo_write in IDLE SHALL start the operation and drop the writes.
REQ-027 done and div_by_zero SHALL be registered, lasting exactly one enabled cycle.

Reset
REQ-028 Reset SHALL asynchronously force the state to IDLE, with hi=0, lo=0, busy=0, done=0, div_by_zero=0, and the counter cleared.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse, and the next start after release SHALL behave normally.

Verification
REQ-030 The bench SHALL cover MULT with op_a=FFFFFFFD and op_b=00000007 -> after 33 edges: done=1, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-031 The bench SHALL cover MULTU with op_a=op_b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-032 The bench SHALL cover DIVU 100/7 -> lo=0000000E, hi=00000002; and DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; and DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-033 The bench SHALL cover DIV 5/0 -> done and div_by_zero=1 two edges after start, hi=00000005, lo=FFFFFFFF.
REQ-034 The bench SHALL cover clk_enable held low for 10 cycles mid-RUN -> done is delayed by exactly 10 cycles and the result is unchanged; a second start while busy is ignored.
REQ-035 The bench SHALL cover reset asserted at iteration 12 -> hi=lo=0 and busy=0 immediately; hi_write of 12345678 in IDLE -> hi=12345678 on the next edge.

Source files
------------

// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: one shift-add or restoring-divide
// step per enabled clock, with sign correction applied in a final cycle.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               zero_div_q, zero_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        is_div_d   = is_div_q;
        zero_div_d = zero_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dz_d       = 1'b0;

        signed_op = ~op[0];
        a_neg     = signed_op & op_a[WIDTH-1];
        b_neg     = signed_op & op_b[WIDTH-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;

        // Multiply: accumulate into the upper half, shift the multiplier out of the lower.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: remainder in the upper half, quotient bits shift in at the bottom.
        div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_rem_sh - {1'b0, b_q};
        div_next   = div_diff[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod = neg_lo_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    b_d      = b_mag;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    if (op[1] && op_b == '0) begin
                        zero_div_d = 1'b1;
                        acc_d      = {op_a, {WIDTH{1'b1}}};
                        state_d    = FINISH;
                    end else begin
                        zero_div_d = 1'b0;
                        acc_d      = {{WIDTH{1'b0}}, a_mag};
                        state_d    = RUN;
                    end
                end else begin
                    if (hi_write) hi_d = write_data;
                    if (lo_write) lo_d = write_data;
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q == CNT_LAST) state_d = FINISH;
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dz_d    = zero_div_q;
                state_d = IDLE;
                if (zero_div_q) begin
                    {hi_d, lo_d} = acc_q;
                end else if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so a post-reset state is fully defined.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            zero_div_q <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else if (clk_enable) begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            zero_div_q <= zero_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
